// File: rtl/gf2k_exp_ctrl.sv
// Square-and-multiply exponentiation in GF(2^DEG): RESULT = BASE^EXP mod POLY.
// A single combinational field multiplier is shared between square and multiply steps.
//
// state | meaning
// IDLE  | waiting for in_valid
// SQR   | acc <= acc*acc, scan exponent bit idx
// MUL   | acc <= acc*base_r for a set exponent bit
// DONE  | RESULT/out_valid presented for one cycle; new request may be taken
module gf2k_exp_ctrl #(
    parameter int DEG = 4,
    parameter int EW  = DEG
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [DEG:0]   POLY,
    input  logic [DEG-1:0] BASE,
    input  logic [EW-1:0]  EXP,
    output logic           busy,
    output logic           out_valid,
    output logic [DEG-1:0] RESULT
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t         state;
    state_t         next_state;
    logic [DEG:0]   poly_r;
    logic [DEG-1:0] base_r;
    logic [EW-1:0]  exp_r;
    logic [DEG-1:0] acc;
    logic [IW-1:0]  idx;
    logic [DEG-1:0] mul_b;
    logic [DEG-1:0] mul_y;
    logic           start;
    logic           exp_bit;
    logic           idx_zero;

    // MSB-first shift-and-add; reduction only applies when the modulus has degree DEG
    function automatic logic [DEG-1:0] gf_mul(input logic [DEG-1:0] a,
                                              input logic [DEG-1:0] b,
                                              input logic [DEG:0]   p);
        logic [DEG-1:0] r;
        r = '0;
        for (int i = DEG - 1; i >= 0; i--) begin
            r = (r << 1) ^ ({DEG{r[DEG-1] & p[DEG]}} & p[DEG-1:0]);
            if (b[i]) begin
                r = r ^ a;
            end
        end
        return r;
    endfunction

    assign start    = in_valid && ((state == IDLE) || (state == DONE));
    assign exp_bit  = exp_r[idx];
    assign idx_zero = (idx == '0);
    assign mul_b    = (state == MUL) ? base_r : acc;
    assign mul_y    = gf_mul(acc, mul_b, poly_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = SQR;
            SQR: begin
                if (exp_bit) begin
                    next_state = MUL;
                end else if (idx_zero) begin
                    next_state = DONE;
                end
            end
            MUL:  next_state = idx_zero ? DONE : SQR;
            DONE: next_state = in_valid ? SQR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SQR) || (state == MUL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_r    <= '0;
            base_r    <= '0;
            exp_r     <= '0;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            RESULT    <= '0;
        end else begin
            if (start) begin
                poly_r <= POLY;
                base_r <= BASE;
                exp_r  <= EXP;
                acc    <= DEG'(1);
                idx    <= IW'(EW - 1);
            end else begin
                case (state)
                    SQR: begin
                        acc <= mul_y;
                        if (!exp_bit && !idx_zero) begin
                            idx <= idx - IW'(1);
                        end
                    end
                    MUL: begin
                        acc <= mul_y;
                        if (!idx_zero) begin
                            idx <= idx - IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            // the last step's product is the final value of acc
            out_valid <= (next_state == DONE);
            RESULT    <= (next_state == DONE) ? mul_y : '0;
        end
    end

endmodule

// File: tb/tb_gf2k_exp_ctrl.sv
// Bench for gf2k_exp_ctrl: naive-power field model with a per-cycle output compare,
// directed latency/result vectors, busy/back-to-back, async reset and random traffic.
module tb_gf2k_exp_ctrl;
    localparam int DEG = 4;
    localparam int EW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic [DEG:0]   POLY = '0;
    logic [DEG-1:0] BASE = '0;
    logic [EW-1:0]  EXP = '0;
    logic           busy;
    logic           out_valid;
    logic [DEG-1:0] RESULT;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;

    // model of the single outstanding operation; cycle k starts at the k-th rising edge
    int m_act = 0;
    int m_start = 0;
    int m_n = 0;
    int m_res = 0;

    gf2k_exp_ctrl #(.DEG(DEG), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .POLY      (POLY),
        .BASE      (BASE),
        .EXP       (EXP),
        .busy      (busy),
        .out_valid (out_valid),
        .RESULT    (RESULT)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // polynomial product over GF(2), then long division by p
    function automatic int gf_mul_m(int a, int b, int p);
        int prod = 0;
        for (int i = 0; i < DEG; i++)
            if (((b >> i) & 1) != 0) prod = prod ^ (a << i);
        for (int i = 2 * DEG - 2; i >= DEG; i--)
            if (((prod >> i) & 1) != 0) prod = prod ^ (p << (i - DEG));
        return prod;
    endfunction

    function automatic int gf_pow_m(int b, int e, int p);
        int r = 1;
        for (int i = 0; i < e; i++) r = gf_mul_m(r, b, p);
        return r;
    endfunction

    function automatic int popc(int e);
        int c = 0;
        for (int i = 0; i < EW; i++) c += (e >> i) & 1;
        return c;
    endfunction

    task automatic chk(string name, int act, int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic tick(bit rst, bit iv, int p, int b, int e);
        @(negedge clk);
        rst_n    = rst;
        in_valid = iv;
        POLY     = p[DEG:0];
        BASE     = b[DEG-1:0];
        EXP      = e[EW-1:0];
        if (!rst) begin
            m_act = 0;
        end else if (iv && (m_act == 0 || cyc >= m_start + m_n + 1)) begin
            m_act   = 1;
            m_start = cyc;
            m_n     = EW + popc(e & 15);
            m_res   = gf_pow_m(b & 15, e & 15, p & 31);
        end
    endtask

    task automatic run_op(int p, int b, int e, int res_req, int lat_req, string name);
        bit got = 0;
        tick(1, 1, p, b, e);
        for (int k = 1; k <= 40 && !got; k++) begin
            tick(1, 0, $urandom, $urandom, $urandom);
            if (out_valid) begin
                got = 1;
                chk({name, " latency"}, k, lat_req);
                chk({name, " result"}, int'(RESULT), res_req);
            end
        end
        if (!got) chk({name, " timeout"}, 0, 1);
    endtask

    always @(posedge clk) begin : compare
        int e_busy;
        int e_ov;
        #1;
        if (!rst_n) begin
            chk("rst busy", int'(busy), 0);
            chk("rst out_valid", int'(out_valid), 0);
            chk("rst result", int'(RESULT), 0);
        end else begin
            e_busy = (m_act != 0 && cyc >= m_start + 1 && cyc <= m_start + m_n) ? 1 : 0;
            e_ov   = (m_act != 0 && cyc == m_start + m_n + 1) ? 1 : 0;
            chk("busy", int'(busy), e_busy);
            chk("out_valid", int'(out_valid), e_ov);
            chk("result", int'(RESULT), (e_ov != 0) ? m_res : 0);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset result", int'(RESULT), 0);

        chk("model 2^4 p13", gf_pow_m(2, 4, 19), 3);
        chk("model 2^15 p13", gf_pow_m(2, 15, 19), 1);
        chk("model 3^2 p13", gf_pow_m(3, 2, 19), 5);
        chk("model 3^0", gf_pow_m(3, 0, 19), 1);
        chk("model 0^3", gf_pow_m(0, 3, 19), 0);
        chk("model 2^4 p19", gf_pow_m(2, 4, 25), 9);

        run_op(19, 2, 4, 3, 6, "b2e4");
        run_op(19, 2, 15, 1, 9, "b2eF");
        run_op(19, 3, 0, 1, 5, "b3e0");
        run_op(19, 0, 3, 0, 7, "b0e3");
        run_op(25, 2, 4, 9, 6, "p19 b2e4");

        // request while busy is dropped; request in DONE is taken
        tick(1, 1, 19, 3, 2);
        for (int k = 1; k <= 14; k++) begin
            tick(1, (k == 2 || k == 6), 19, (k == 6) ? 2 : 7, (k == 6) ? 4 : 15);
            if (k == 2) chk("b2b busy", int'(busy), 1);
            if (k == 6) begin
                chk("b2b first ov", int'(out_valid), 1);
                chk("b2b first result", int'(RESULT), 5);
            end
            if (k == 11) chk("b2b ignored ov", int'(out_valid), 0);
            if (k == 12) begin
                chk("b2b second ov", int'(out_valid), 1);
                chk("b2b second result", int'(RESULT), 3);
            end
        end

        // asynchronous abort in the middle of an EXP=F operation
        tick(1, 1, 19, 2, 15);
        tick(1, 0, 19, 2, 15);
        tick(1, 0, 19, 2, 15);
        @(posedge clk);
        chk("pre-abort busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        m_act = 0;
        #1;
        chk("async busy", int'(busy), 0);
        chk("async out_valid", int'(out_valid), 0);
        chk("async result", int'(RESULT), 0);
        repeat (3) tick(0, 0, 19, 2, 15);
        run_op(19, 2, 4, 3, 6, "after reset");

        for (int i = 0; i < 40000; i++)
            tick(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 19 : 25,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        repeat (12) tick(1, 0, 19, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/gf2k_exp_ctrl.md
GF2K_EXP_CTRL -- requirements
Module: gf2k_exp_ctrl

Interface
REQ-001 The block SHALL have parameter DEG, default 4, giving the field degree. Operand width is DEG; the polynomial width is DEG+1.
REQ-002 The block SHALL have parameter EW, default DEG, giving the exponent width.
REQ-003 Port clk, input, 1 bit: the single clock. All state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: start request. POLY, BASE and EXP are sampled when in_valid=1 in IDLE or DONE.
REQ-006 Port POLY, input, DEG+1 bits: irreducible reduction polynomial, with POLY[DEG]=1.
REQ-007 Port BASE, input, DEG bits: the field element to be raised to a power.
REQ-008 Port EXP, input, EW bits: unsigned exponent.
REQ-009 Port busy, output, 1 bit: high while in SQR or MUL.
REQ-010 Port out_valid, output, 1 bit: result strobe, high for one cycle.
REQ-011 Port RESULT, output, DEG bits: BASE^EXP in GF(2^DEG) modulo POLY. It is valid only while out_valid=1 and is 0 otherwise.

Function
REQ-012 The block SHALL contain exactly one combinational GF(2^DEG) multiplier (operands a, b, modulus POLY). That multiplier SHALL be used at most once per cycle.
REQ-013 Captured registers SHALL be: poly_r, base_r, exp_r, accumulator acc (DEG bits), and bit index idx (counts EW-1 down to 0).
REQ-014 FSM states SHALL be IDLE, SQR, MUL, DONE, with encoding free.
REQ-015 IDLE or DONE with in_valid=1: capture inputs, set acc=1, set idx=EW-1, go to SQR.
REQ-016 IDLE with in_valid=0: stay in IDLE. DONE with in_valid=0: go to IDLE.
REQ-017 SQR: acc <= acc*acc mod poly_r. Then:
- if exp_r[idx]=1, go to MUL;
- otherwise, if idx=0, go to DONE;
- otherwise, idx <= idx-1 and stay in SQR.
REQ-018 MUL: acc <= acc*base_r mod poly_r. Then, if idx=0, go to DONE; otherwise idx <= idx-1 and go to SQR.
REQ-019 On entry to DONE, RESULT SHALL be acc and out_valid SHALL be 1 for exactly one cycle. Both SHALL be registered outputs.
REQ-020 Latency: with in_valid sampled at edge T0 and N = EW + popcount(EXP):
- out_valid SHALL be high in the cycle starting at edge T0+N+1;
- busy SHALL be high in cycles T0+1 through T0+N.
REQ-021 in_valid while busy=1 SHALL be ignored: no capture, no state change, no error flag.
REQ-022 in_valid=1 in the DONE cycle SHALL be accepted (back-to-back operation) while the current RESULT is still presented. The next out_valid SHALL follow per REQ-020.
REQ-023 Boundary cases:
- EXP=0 SHALL yield RESULT=1 after EW cycles;
- BASE=0 with EXP≠0 SHALL yield 0;
- EXP all-ones SHALL take 2·EW cycles.
REQ-024 Input ports SHALL NOT be read after capture. Changing POLY, BASE or EXP mid-operation SHALL NOT affect the result.
REQ-025 Behaviour with POLY[DEG]=0 is out of scope. The FSM SHALL still terminate with N as defined in REQ-020.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk:
- force state=IDLE;
- clear busy, out_valid and RESULT to 0;
- clear acc, idx and all captured registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no out_valid. After release the block SHALL be in IDLE and accept in_valid on the first rising edge.

Verification
REQ-028 DEG=4, POLY=5'b10011, BASE=4'h2, EXP=4'h4 -> out_valid at T0+6 with RESULT=4'h3. busy high for cycles T0+1..T0+5.
REQ-029 Same POLY, BASE=4'h2, EXP=4'hF -> out_valid at T0+9 with RESULT=4'h1.
REQ-030 BASE=4'h3, EXP=4'h0 -> out_valid at T0+5 with RESULT=4'h1. BASE=4'h0, EXP=4'h3 -> out_valid at T0+7 with RESULT=4'h0.
REQ-031 Busy and back-to-back behaviour:
- in_valid pulsed with BASE=4'h3, EXP=4'h2 -> RESULT=4'h5 at T0+6;
- a second in_valid while busy SHALL be ignored;
- a third in_valid in the DONE cycle SHALL be accepted and produce a second out_valid at the expected time.
REQ-032 rst_n dropped at T0+3 of an EXP=4'hF operation -> outputs are 0 asynchronously and no out_valid appears. A fresh request after release SHALL complete correctly.
REQ-033 Random regression of at least 10k operations against a software GF(2^4) power model, with random in_valid gaps and POLY ∈ {10011, 11001}. Every out_valid SHALL match the model and arrive at the latency given by REQ-020.
